// File: rtl/rv32m_muldiv_if.sv
// Request/response bundle for the RV32M multiply/divide unit.
// master drives start/funct3/op_a/op_b/rd_in; slave returns busy/done/result/rd_out.
interface rv32m_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, funct3, op_a, op_b, rd_in,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, op_a, op_b, rd_in,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/rv32m_muldiv.sv
// Iterative RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU unit; clk, async rst, bus (slave).
// Macro FAST_MUL_EN: multiplies use a single combinational product of the latched operands.
module rv32m_muldiv #(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rst,
  rv32m_muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [2:0]        fn;
  logic [XLEN-1:0]   magA;
  logic [XLEN-1:0]   magB;
  logic              aNeg;
  logic              bNeg;
  logic [2*XLEN-1:0] acc;
  logic [4:0]        rdHold;
  logic              busyQ;
  logic              doneQ;
  logic [XLEN-1:0]   resultQ;
  logic [4:0]        rdOutQ;

  assign bus.busy   = busyQ;
  assign bus.done   = doneQ;
  assign bus.result = resultQ;
  assign bus.rd_out = rdOutQ;

  logic            sgnA;
  logic            sgnB;
  logic            inNegA;
  logic            inNegB;
  logic [XLEN-1:0] inMagA;
  logic [XLEN-1:0] inMagB;
  logic            divZero;

  always_comb begin
    sgnA = 1'b0;
    sgnB = 1'b0;
    case (bus.funct3)
      3'b001, 3'b100, 3'b110: begin
        sgnA = 1'b1;
        sgnB = 1'b1;
      end
      3'b010: sgnA = 1'b1;
      default: ;
    endcase
    inNegA  = sgnA & bus.op_a[XLEN-1];
    inNegB  = sgnB & bus.op_b[XLEN-1];
    inMagA  = inNegA ? -bus.op_a : bus.op_a;
    inMagB  = inNegB ? -bus.op_b : bus.op_b;
    divZero = bus.funct3[2] & (bus.op_b == '0);
  end

  // acc is shared: {hi, multiplier} for shift-add, {remainder, dividend/quotient}
  // for restoring division.
  logic [XLEN:0]     sum;
  logic [XLEN:0]     shifted;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] accNext;
  logic [2*XLEN-1:0] accFin;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   resNext;
  logic              lastIter;

  always_comb begin
    sum     = {1'b0, acc[2*XLEN-1:XLEN]}
            + (acc[0] ? {1'b0, magA} : '0);
    shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff    = shifted - {1'b0, magB};
    if (!fn[2])
      accNext = {sum, acc[XLEN-1:1]};
    else if (diff[XLEN])
      accNext = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      accNext = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

`ifdef FAST_MUL_EN
  logic [2*XLEN-1:0] fastProd;
  assign fastProd = {{XLEN{1'b0}}, magA} * {{XLEN{1'b0}}, magB};
  assign accFin   = fn[2] ? accNext : fastProd;
  assign lastIter = !fn[2] || (cnt == LAST);
`else
  assign accFin   = accNext;
  assign lastIter = (cnt == LAST);
`endif

  // Magnitudes were used throughout; signs are reapplied here.
  always_comb begin
    prod = (aNeg ^ bNeg) ? -accFin : accFin;
    quo  = accFin[XLEN-1:0];
    rem  = accFin[2*XLEN-1:XLEN];
    case (fn)
      3'b000:                 resNext = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: resNext = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         resNext = (aNeg ^ bNeg) ? -quo : quo;
      default:                resNext = aNeg ? -rem : rem;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      fn      <= '0;
      magA    <= '0;
      magB    <= '0;
      aNeg    <= 1'b0;
      bNeg    <= 1'b0;
      acc     <= '0;
      rdHold  <= '0;
      busyQ   <= 1'b0;
      doneQ   <= 1'b0;
      resultQ <= '0;
      rdOutQ  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            fn     <= bus.funct3;
            magA   <= inMagA;
            magB   <= inMagB;
            aNeg   <= inNegA;
            bNeg   <= inNegB;
            rdHold <= bus.rd_in;
            cnt    <= '0;
            busyQ  <= 1'b1;
            acc    <= bus.funct3[2]
                    ? {{XLEN{1'b0}}, inMagA}
                    : {{XLEN{1'b0}}, inMagB};
            if (divZero) begin
              state   <= DONE;
              doneQ   <= 1'b1;
              rdOutQ  <= bus.rd_in;
              resultQ <= bus.funct3[1] ? bus.op_a : '1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= accFin;
          cnt <= cnt + CW'(1);
          if (lastIter) begin
            state   <= DONE;
            doneQ   <= 1'b1;
            resultQ <= resNext;
            rdOutQ  <= rdHold;
          end
        end
        DONE: begin
          state <= IDLE;
          busyQ <= 1'b0;
          doneQ <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rv32m_muldiv.sv
// Self-checking bench for rv32m_muldiv: directed RV32M cases, random ops
// against an arithmetic reference, start-hold and mid-operation reset.
module tb_rv32m_muldiv;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  rv32m_muldiv_if #(.XLEN(XLEN)) bus ();

  rv32m_muldiv #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RISC-V M semantics straight from the ISA rules using 64-bit arithmetic.
  function automatic logic [31:0] refModel(logic [2:0] f,
                                           logic [31:0] a,
                                           logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return '1;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  task automatic runOp(string tag, logic [2:0] f, logic [31:0] a,
                       logic [31:0] b, logic [4:0] rd,
                       logic [31:0] expRes);
    int n;
    int expLat;
    expLat = (f[2] && b == 0) ? 1 : XLEN + 1;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.rd_in  = rd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check({tag, ".busy"}, 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        bus.op_a  = ~a;
        bus.op_b  = ~b ^ 32'd1;
        bus.rd_in = ~rd;
      end
    end while (!bus.done && n < 100);
    check({tag, ".lat"}, 32'(n), 32'(expLat));
    check({tag, ".res"}, bus.result, expRes);
    check({tag, ".rd"}, 32'(bus.rd_out), 32'(rd));
    @(negedge clk);
    check({tag, ".idle"}, {30'b0, bus.busy, bus.done}, 32'd0);
    check({tag, ".hold"}, bus.result, expRes);
  endtask

  initial begin
    int n;
    int dones;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;

    rst = 1'b1;
    bus.start  = 1'b0;
    bus.funct3 = '0;
    bus.op_a   = '0;
    bus.op_b   = '0;
    bus.rd_in  = '0;
    @(negedge clk);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check("rst.result", bus.result, 32'd0);
    check("rst.rd", 32'(bus.rd_out), 32'd0);
    rst = 1'b0;

    runOp("mul", 3'd0, 32'd7, 32'd6, 5'd5, 32'h0000002A);
    runOp("mulh", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'h0);
    runOp("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE);
    runOp("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2, 5'd3, 32'hFFFFFFFF);
    runOp("div", 3'd4, 32'hFFFFFFF9, 32'd2, 5'd4, 32'hFFFFFFFD);
    runOp("rem", 3'd6, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF);
    runOp("divu", 3'd5, 32'd100, 32'd7, 5'd7, 32'd14);
    runOp("remu", 3'd7, 32'd100, 32'd7, 5'd8, 32'd2);
    runOp("div0", 3'd4, 32'd5, 32'd0, 5'd9, 32'hFFFFFFFF);
    runOp("rem0", 3'd6, 32'd5, 32'd0, 5'd10, 32'd5);
    runOp("divu0", 3'd5, 32'd9, 32'd0, 5'd11, 32'hFFFFFFFF);
    runOp("remu0", 3'd7, 32'd9, 32'd0, 5'd12, 32'd9);
    runOp("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000);
    runOp("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h0);

    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      runOp($sformatf("rnd%0d", i), f, a, b, 5'($urandom_range(0, 31)),
            refModel(f, a, b));
    end

    // start held through the operation, operands disturbed mid-flight
    a = 32'hDEADBEEF;
    b = 32'h12345678;
    e = refModel(3'd3, a, b);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'd3;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.rd_in  = 5'd21;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 5) begin
        bus.op_a   = 32'd0;
        bus.op_b   = 32'd0;
        bus.funct3 = 3'd4;
      end
    end while (!bus.done && n < 100);
    bus.start = 1'b0;
    check("hold.lat", 32'(n), 32'(XLEN + 1));
    check("hold.res", bus.result, e);
    check("hold.rd", 32'(bus.rd_out), 32'd21);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("hold.extra", 32'(dones), 32'd0);
    check("hold.keep", bus.result, e);

    // reset in the middle of a division
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = 3'd5;
    bus.op_a   = 32'd1000;
    bus.op_b   = 32'd3;
    bus.rd_in  = 5'd17;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) bus.start = 1'b0;
    end while (n < 10);
    rst = 1'b1;
    #1;
    check("abort.busy", 32'(bus.busy), 32'd0);
    check("abort.done", 32'(bus.done), 32'd0);
    check("abort.res", bus.result, 32'd0);
    check("abort.rd", 32'(bus.rd_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("abort.nodone", 32'(dones), 32'd0);
    runOp("after", 3'd5, 32'd1000, 32'd3, 5'd17, 32'd333);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
